// File: rtl/register_bank.sv
// Parametrised general-purpose register file: NUM_REGS registers sharing one FunSel
// operation and input bus, with per-register enables, two read ports and an overflow pulse.
module register_bank #(
   parameter int WIDTH = 16,
   parameter int NUM_REGS = 4,
   parameter int SATURATE = 0,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   localparam int SEL_W = $clog2(NUM_REGS)
) (
   input  logic                Clock,
   input  logic                Reset_n,
   input  logic [NUM_REGS-1:0] E,
   input  logic [2:0]          FunSel,
   input  logic [WIDTH-1:0]    I,
   input  logic [SEL_W-1:0]    SelA,
   input  logic [SEL_W-1:0]    SelB,
   output logic [WIDTH-1:0]    OutA,
   output logic [WIDTH-1:0]    OutB,
   output logic                ZeroA,
   output logic                Ovf
);

   localparam int HALF = WIDTH / 2;
   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONES = '1;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [SEL_W:0] REG_LIMIT = (SEL_W + 1)'(NUM_REGS);

   logic [WIDTH-1:0] regs      [NUM_REGS];
   logic [WIDTH-1:0] next_regs [NUM_REGS];
   logic             ovf_hit;
   logic [HALF-1:0]  low_in;

   assign low_in = I[HALF-1:0];

   always_comb begin
      ovf_hit = 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
         next_regs[k] = regs[k];
         if (E[k]) begin
            case (FunSel)
               3'b000: begin
                  // Decrement at zero either wraps or clamps; both count as overflow
                  if (regs[k] == ZERO) begin
                     ovf_hit      = 1'b1;
                     next_regs[k] = (SATURATE != 0) ? ZERO : ONES;
                  end else begin
                     next_regs[k] = regs[k] - ONE;
                  end
               end
               3'b001: begin
                  if (regs[k] == ONES) begin
                     ovf_hit      = 1'b1;
                     next_regs[k] = (SATURATE != 0) ? ONES : ZERO;
                  end else begin
                     next_regs[k] = regs[k] + ONE;
                  end
               end
               3'b010:  next_regs[k] = I;
               3'b011:  next_regs[k] = ZERO;
               3'b100:  next_regs[k] = {{HALF{1'b0}}, low_in};
               3'b101:  next_regs[k] = {regs[k][WIDTH-1:HALF], low_in};
               3'b110:  next_regs[k] = {low_in, regs[k][HALF-1:0]};
               default: next_regs[k] = {{HALF{low_in[HALF-1]}}, low_in};
            endcase
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            regs[k] <= RESET_VALUE;
         end
         Ovf <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            regs[k] <= next_regs[k];
         end
         Ovf <= ovf_hit;
      end
   end

   // Selects beyond the last register read as zero rather than indexing past the array
   always_comb begin
      OutA = ZERO;
      OutB = ZERO;
      if ({1'b0, SelA} < REG_LIMIT) begin
         OutA = regs[SelA];
      end
      if ({1'b0, SelB} < REG_LIMIT) begin
         OutB = regs[SelB];
      end
   end

   assign ZeroA = (OutA == ZERO);

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: a wrapping bank, a saturating bank, and a
// three-register bank with a non-zero reset value.
module tb_register_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Bank A: defaults (wrap, 4 regs, reset 0)
   logic        a_rstn;
   logic [3:0]  a_e;
   logic [2:0]  a_fs;
   logic [15:0] a_i;
   logic [1:0]  a_sela, a_selb;
   logic [15:0] a_outa, a_outb;
   logic        a_zeroa, a_ovf;

   // Bank B: saturating
   logic        b_rstn;
   logic [3:0]  b_e;
   logic [2:0]  b_fs;
   logic [15:0] b_i;
   logic [1:0]  b_sela, b_selb;
   logic [15:0] b_outa, b_outb;
   logic        b_zeroa, b_ovf;

   // Bank C: three registers, reset value 0x00FF
   logic        c_rstn;
   logic [2:0]  c_e;
   logic [2:0]  c_fs;
   logic [15:0] c_i;
   logic [1:0]  c_sela, c_selb;
   logic [15:0] c_outa, c_outb;
   logic        c_zeroa, c_ovf;

   register_bank u_a (
      .Clock(clk), .Reset_n(a_rstn), .E(a_e), .FunSel(a_fs), .I(a_i),
      .SelA(a_sela), .SelB(a_selb), .OutA(a_outa), .OutB(a_outb),
      .ZeroA(a_zeroa), .Ovf(a_ovf)
   );

   register_bank #(.SATURATE(1)) u_b (
      .Clock(clk), .Reset_n(b_rstn), .E(b_e), .FunSel(b_fs), .I(b_i),
      .SelA(b_sela), .SelB(b_selb), .OutA(b_outa), .OutB(b_outb),
      .ZeroA(b_zeroa), .Ovf(b_ovf)
   );

   register_bank #(.NUM_REGS(3), .RESET_VALUE(16'h00FF)) u_c (
      .Clock(clk), .Reset_n(c_rstn), .E(c_e), .FunSel(c_fs), .I(c_i),
      .SelA(c_sela), .SelB(c_selb), .OutA(c_outa), .OutB(c_outb),
      .ZeroA(c_zeroa), .Ovf(c_ovf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op_a(input logic [3:0] e, input logic [2:0] fs, input logic [15:0] i);
      a_e = e; a_fs = fs; a_i = i;
      tick();
   endtask

   task automatic op_b(input logic [3:0] e, input logic [2:0] fs, input logic [15:0] i);
      b_e = e; b_fs = fs; b_i = i;
      tick();
   endtask

   task automatic op_c(input logic [2:0] e, input logic [2:0] fs, input logic [15:0] i);
      c_e = e; c_fs = fs; c_i = i;
      tick();
   endtask

   task automatic test_reset();
      op_a(4'b0011, 3'b010, 16'hFFFF);
      op_a(4'b0001, 3'b001, 16'h0000);
      checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL pre_reset_ovf: got %b expected 1", a_ovf); end
      a_e = 4'b0000;
      a_sela = 2'd1; a_selb = 2'd1;
      #3 a_rstn = 1'b0;
      #1;
      checks++; if (a_outa !== 16'h0000) begin errors++; $display("FAIL reset_outa: got %h expected 0000", a_outa); end
      checks++; if (a_outb !== 16'h0000) begin errors++; $display("FAIL reset_outb: got %h expected 0000", a_outb); end
      checks++; if (a_zeroa !== 1'b1) begin errors++; $display("FAIL reset_zeroa: got %b expected 1", a_zeroa); end
      checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", a_ovf); end
      #2 a_rstn = 1'b1;
      a_sela = 2'd0;
      op_a(4'b0001, 3'b010, 16'hBEEF);
      checks++; if (a_outa !== 16'hBEEF) begin errors++; $display("FAIL load_beef: got %h expected beef", a_outa); end
      checks++; if (a_zeroa !== 1'b0) begin errors++; $display("FAIL load_zeroa: got %b expected 0", a_zeroa); end
   endtask

   task automatic test_half_ops();
      a_sela = 2'd1; a_selb = 2'd0;
      op_a(4'b0010, 3'b010, 16'h1234);
      op_a(4'b0010, 3'b101, 16'h00AB);
      checks++; if (a_outa !== 16'h12AB) begin errors++; $display("FAIL half_low: got %h expected 12ab", a_outa); end
      op_a(4'b0010, 3'b110, 16'h00CD);
      checks++; if (a_outa !== 16'hCDAB) begin errors++; $display("FAIL half_high: got %h expected cdab", a_outa); end
      op_a(4'b0010, 3'b100, 16'hFF80);
      checks++; if (a_outa !== 16'h0080) begin errors++; $display("FAIL zero_ext: got %h expected 0080", a_outa); end
      op_a(4'b0010, 3'b111, 16'h0080);
      checks++; if (a_outa !== 16'hFF80) begin errors++; $display("FAIL sign_ext_neg: got %h expected ff80", a_outa); end
      op_a(4'b0010, 3'b111, 16'h007F);
      checks++; if (a_outa !== 16'h007F) begin errors++; $display("FAIL sign_ext_pos: got %h expected 007f", a_outa); end
      checks++; if (a_outb !== 16'hBEEF) begin errors++; $display("FAIL hold_r0: got %h expected beef", a_outb); end
   endtask

   task automatic test_wrap();
      a_sela = 2'd2;
      op_a(4'b0100, 3'b010, 16'hFFFF);
      checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL load_no_ovf: got %b expected 0", a_ovf); end
      op_a(4'b0100, 3'b001, 16'h0000);
      checks++; if (a_outa !== 16'h0000) begin errors++; $display("FAIL inc_wrap: got %h expected 0000", a_outa); end
      checks++; if (a_zeroa !== 1'b1) begin errors++; $display("FAIL inc_wrap_zeroa: got %b expected 1", a_zeroa); end
      checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL inc_wrap_ovf: got %b expected 1", a_ovf); end
      op_a(4'b0100, 3'b000, 16'h0000);
      checks++; if (a_outa !== 16'hFFFF) begin errors++; $display("FAIL dec_wrap: got %h expected ffff", a_outa); end
      checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL dec_wrap_ovf: got %b expected 1", a_ovf); end
      op_a(4'b0000, 3'b001, 16'h0000);
      checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL idle_ovf: got %b expected 0", a_ovf); end
      checks++; if (a_outa !== 16'hFFFF) begin errors++; $display("FAIL idle_hold: got %h expected ffff", a_outa); end
   endtask

   task automatic test_saturate();
      b_sela = 2'd3;
      op_b(4'b1000, 3'b010, 16'hFFFF);
      op_b(4'b1000, 3'b001, 16'h0000);
      checks++; if (b_outa !== 16'hFFFF) begin errors++; $display("FAIL sat_inc: got %h expected ffff", b_outa); end
      checks++; if (b_ovf !== 1'b1) begin errors++; $display("FAIL sat_inc_ovf: got %b expected 1", b_ovf); end
      op_b(4'b1000, 3'b011, 16'h1234);
      checks++; if (b_ovf !== 1'b0) begin errors++; $display("FAIL clear_no_ovf: got %b expected 0", b_ovf); end
      op_b(4'b1000, 3'b000, 16'h0000);
      checks++; if (b_outa !== 16'h0000) begin errors++; $display("FAIL sat_dec: got %h expected 0000", b_outa); end
      checks++; if (b_ovf !== 1'b1) begin errors++; $display("FAIL sat_dec_ovf: got %b expected 1", b_ovf); end
      op_b(4'b1000, 3'b010, 16'h0005);
      op_b(4'b1000, 3'b000, 16'h0000);
      checks++; if (b_outa !== 16'h0004) begin errors++; $display("FAIL sat_dec_normal: got %h expected 0004", b_outa); end
      checks++; if (b_ovf !== 1'b0) begin errors++; $display("FAIL sat_dec_normal_ovf: got %b expected 0", b_ovf); end
   endtask

   task automatic test_parallel();
      logic [15:0] expected [4];
      expected[0] = 16'h0000; expected[1] = 16'hFFFF;
      expected[2] = 16'h7FFE; expected[3] = 16'h0FFF;
      op_a(4'b0001, 3'b010, 16'h0001);
      op_a(4'b0010, 3'b010, 16'h0000);
      op_a(4'b0100, 3'b010, 16'h7FFF);
      op_a(4'b1000, 3'b010, 16'h1000);
      op_a(4'b1111, 3'b000, 16'h0000);
      a_e = 4'b0000;
      checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL parallel_ovf: got %b expected 1", a_ovf); end
      for (int k = 0; k < 4; k++) begin
         a_sela = 2'(k);
         #1;
         checks++; if (a_outa !== expected[k]) begin errors++; $display("FAIL parallel_r%0d: got %h expected %h", k, a_outa, expected[k]); end
      end
      a_sela = 2'd1; a_selb = 2'd1;
      #1;
      checks++; if (a_outa !== 16'hFFFF || a_outb !== 16'hFFFF) begin errors++; $display("FAIL same_sel: got %h/%h expected ffff/ffff", a_outa, a_outb); end
   endtask

   task automatic test_async_reset();
      c_sela = 2'd0; c_selb = 2'd1;
      op_c(3'b001, 3'b010, 16'h0010);
      op_c(3'b111, 3'b001, 16'h0000);
      checks++; if (c_outa !== 16'h0011 || c_outb !== 16'h0100) begin errors++; $display("FAIL c_inc: got %h/%h expected 0011/0100", c_outa, c_outb); end
      #3 c_rstn = 1'b0;
      #1;
      checks++; if (c_outa !== 16'h00FF || c_outb !== 16'h00FF) begin errors++; $display("FAIL c_async_reset: got %h/%h expected 00ff/00ff", c_outa, c_outb); end
      c_sela = 2'd2;
      #1;
      checks++; if (c_outa !== 16'h00FF) begin errors++; $display("FAIL c_async_reset_r2: got %h expected 00ff", c_outa); end
      tick();
      checks++; if (c_outa !== 16'h00FF || c_ovf !== 1'b0) begin errors++; $display("FAIL c_reset_hold: got %h ovf %b expected 00ff ovf 0", c_outa, c_ovf); end
      #2 c_rstn = 1'b1;
      tick();
      checks++; if (c_outa !== 16'h0100) begin errors++; $display("FAIL c_inc_after_release: got %h expected 0100", c_outa); end
      c_sela = 2'd3; c_selb = 2'd3;
      #1;
      checks++; if (c_outa !== 16'h0000 || c_zeroa !== 1'b1) begin errors++; $display("FAIL c_out_of_range_a: got %h zero %b expected 0000 zero 1", c_outa, c_zeroa); end
      checks++; if (c_outb !== 16'h0000) begin errors++; $display("FAIL c_out_of_range_b: got %h expected 0000", c_outb); end
   endtask

   initial begin
      a_rstn = 1'b0; a_e = '0; a_fs = '0; a_i = '0; a_sela = '0; a_selb = '0;
      b_rstn = 1'b0; b_e = '0; b_fs = '0; b_i = '0; b_sela = '0; b_selb = '0;
      c_rstn = 1'b0; c_e = '0; c_fs = '0; c_i = '0; c_sela = '0; c_selb = '0;
      #12;
      a_rstn = 1'b1; b_rstn = 1'b1; c_rstn = 1'b1;
      tick();
      test_reset();
      test_half_ops();
      test_wrap();
      test_saturate();
      test_parallel();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised successor to the single 16-bit FunSel register.
- Holds NUM_REGS registers of WIDTH bits. Each register has its own enable. All registers share one FunSel operation and one input bus.
- Two combinational read ports, a zero flag, and a registered overflow/saturation pulse.
- Serves as the general-purpose / address register file of the datapath, feeding the ALU and memory-address muxes.

Parameters:
- WIDTH, 16, register width in bits; must be even and ≥ 4; HALF = WIDTH/2.
- NUM_REGS, 4, number of registers; ≥ 2.
- SATURATE, 0, 0 = inc/dec wrap modulo 2^WIDTH; 1 = inc clamps at all-ones, dec clamps at zero.
- RESET_VALUE, 0, value loaded into every register on reset (WIDTH bits).

Ports:
- Clock  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- E  input  NUM_REGS  per-register enable, one bit per register.
- FunSel  input  3  operation applied to every enabled register.
- I  input  WIDTH  data input.
- SelA  input  $clog2(NUM_REGS)  read port A select.
- SelB  input  $clog2(NUM_REGS)  read port B select.
- OutA  output  WIDTH  contents of register SelA.
- OutB  output  WIDTH  contents of register SelB.
- ZeroA  output  1  high when OutA == 0.
- Ovf  output  1  registered one-cycle pulse (see Behaviour).

Behaviour:
- Reset (Reset_n low, asynchronous, independent of Clock):
  - All registers = RESET_VALUE; Ovf = 0.
  - Holds while low; first update happens on the first rising edge after release.
  - Reset asserted mid-operation aborts it; no partial write survives.
- Register update: on each rising Clock edge, every register k with E[k]=1 applies FunSel. Registers with E[k]=0 hold.
- FunSel encoding (R = register, L = I[HALF-1:0]):
  - 000: R = R − 1.
  - 001: R = R + 1.
  - 010: R = I.
  - 011: R = 0.
  - 100: R = {HALF zeros, L}.
  - 101: R[HALF-1:0] = L; upper half unchanged.
  - 110: R[WIDTH-1:HALF] = L; lower half unchanged.
  - 111: R = {HALF copies of I[HALF-1], L} (sign-extend).
- Arithmetic boundaries:
  - SATURATE=0: all-ones + 1 → 0; 0 − 1 → all-ones.
  - SATURATE=1: all-ones + 1 stays all-ones; 0 − 1 stays 0.
- Ovf:
  - Set to 1 on the edge after a cycle in which any enabled register performed inc at all-ones or dec at zero (wrap or clamp). Otherwise 0 on that edge.
  - Exactly one cycle per offending edge; back-to-back offending cycles give continuous high.
  - Ovf is not set by loads or clear.
- Multiple E bits set: each enabled register performs the operation independently on its own value. Ovf is the OR of all wrap/clamp events.
- E all zero: no register changes; Ovf goes to 0 on the next edge.
- Read ports:
  - Purely combinational from current register state. Same-edge writes become visible after the edge (no write-through).
  - SelA and SelB may be equal.
  - A select value ≥ NUM_REGS drives the output to 0; ZeroA=1 in that case.
- Synthesis: no latches; all storage is edge-triggered on Clock with the async clear/preset from Reset_n.

Test Plan (WIDTH=16, NUM_REGS=4, RESET_VALUE=0 unless noted):
1. Reset and load:
   - Reset_n=0 mid-cycle → OutA=OutB=0, ZeroA=1, Ovf=0 immediately.
   - Release; E=0001, FunSel=010, I=0xBEEF, one edge; SelA=0 → OutA=0xBEEF, ZeroA=0.
2. Half and sign-extend ops on R1 = 0x1234:
   - FunSel=101, I=0x00AB → 0x12AB.
   - FunSel=110, I=0x00CD → 0xCDAB.
   - FunSel=100, I=0xFF80 → 0x0080.
   - FunSel=111, I=0x0080 → 0xFF80.
   - FunSel=111, I=0x007F → 0x007F.
3. Wrap with SATURATE=0:
   - R2=0xFFFF, FunSel=001 → R2=0x0000; Ovf=1 for exactly one cycle after the edge.
   - Then FunSel=000 → R2=0xFFFF, Ovf=1.
   - Then E=0 → Ovf=0.
4. Clamp with SATURATE=1:
   - R3=0xFFFF, inc → stays 0xFFFF, Ovf=1.
   - R3=0, dec → stays 0, Ovf=1.
   - R3=5, dec → 4, Ovf=0.
5. Parallel enable:
   - R0=0x0001, R1=0x0000, R2=0x7FFF, R3=0x1000.
   - E=1111, FunSel=000 → 0x0000, 0xFFFF, 0x7FFE, 0x0FFF; Ovf=1 (from R1).
   - SelA=SelB=1 → both outputs 0xFFFF.
6. Async reset and out-of-range select:
   - Async reset pulse between edges during an inc sequence, RESET_VALUE=0x00FF → all registers 0x00FF at once; no increment on the following edge while Reset_n is low.
   - With NUM_REGS=3, SelA=3 → OutA=0, ZeroA=1.
